// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and flag bit positions shared by the issue unit and flag logic
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_NOR = 4'd4,
    OP_XOR = 4'd5,
    OP_LSL = 4'd6,
    OP_LSR = 4'd7,
    OP_ASR = 4'd8
  } op_e;
  localparam logic [3:0] OP_LAST = 4'd8;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_flags.sv
// alu_flags: combinational {N,Z,C,V} generation; carry/overflow come from a private add/sub
module alu_flags import alu_pkg::*; #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] y_i,
  input  logic [3:0]   op_i,
  input  logic         err_i,
  output logic [3:0]   flags_o
);
  logic         sub;
  logic         arith;
  logic [N:0]   sum;
  always_comb begin
    sub = op_i == OP_SUB;
    arith = !err_i && (op_i == OP_ADD || sub);
    sum = {1'b0, a_i} + {1'b0, sub ? ~b_i : b_i} + {{N{1'b0}}, sub};
    flags_o = '0;
    flags_o[FLAG_N] = y_i[N-1];
    flags_o[FLAG_Z] = y_i == '0;
    flags_o[FLAG_C] = arith & sum[N];
    flags_o[FLAG_V] = arith & (a_i[N-1] ^ sum[N-1]) & ~(a_i[N-1] ^ b_i[N-1] ^ sub);
  end
endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: two-stage valid/ready pipeline around an external combinational ALU
module alu_issue_unit import alu_pkg::*; #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic [3:0]   out_flags,
  output logic         out_err,
  output logic [15:0]  op_count
);
  logic         s1_valid_q, s1_valid_d, s1_err_q, s1_err_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]   ctrl_q, ctrl_d;
  logic         s2_valid_q, s2_valid_d, err_q, err_d;
  logic [N-1:0] y_q, y_d, y_s1;
  logic [3:0]   flags_q, flags_d, flags_s1;
  logic [15:0]  cnt_q, cnt_d;
  logic         s1_adv, s2_adv, take, legal;
  // illegal ops reach S2 as a zero result so Z is the only flag they raise
  assign y_s1 = s1_err_q ? '0 : alu_y;
  alu_flags #(.N(N)) u_flags (
    .a_i    (a_q),
    .b_i    (b_q),
    .y_i    (y_s1),
    .op_i   (ctrl_q),
    .err_i  (s1_err_q),
    .flags_o(flags_s1)
  );
  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    take = in_valid && s1_adv;
    legal = in_op <= OP_LAST;
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    a_d = take ? in_a : a_q;
    b_d = take ? in_b : b_q;
    ctrl_d = take ? (legal ? in_op : 4'd0) : ctrl_q;
    s1_err_d = take ? !legal : s1_err_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    y_d = s2_adv && s1_valid_q ? y_s1 : y_q;
    flags_d = s2_adv && s1_valid_q ? flags_s1 : flags_q;
    err_d = s2_adv && s1_valid_q ? s1_err_q : err_q;
    cnt_d = cnt_q + {15'd0, s2_valid_q && out_ready};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_err_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      ctrl_q <= '0;
      s2_valid_q <= 1'b0;
      y_q <= '0;
      flags_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q <= s1_err_d;
      a_q <= a_d;
      b_q <= b_d;
      ctrl_q <= ctrl_d;
      s2_valid_q <= s2_valid_d;
      y_q <= y_d;
      flags_q <= flags_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = s1_adv;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_ctrl = ctrl_q;
  assign out_valid = s2_valid_q;
  assign out_y = y_q;
  assign out_flags = flags_q;
  assign out_err = err_q;
  assign op_count = cnt_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed vectors plus stall and reset sequences around a behavioural ALU
module tb_alu_issue_unit;
  logic        clk = 0, reset = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, out_err;
  logic [3:0]  in_op = 0, alu_ctrl, out_flags;
  logic [31:0] in_a = 0, in_b = 0, alu_a, alu_b, alu_y, out_y;
  logic [15:0] op_count;
  int checks = 0, errors = 0;
  alu_issue_unit #(.N(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_flags(out_flags), .out_err(out_err), .op_count(op_count)
  );
  always #5 clk = ~clk;
  always_comb begin
    case (alu_ctrl)
      4'd0: alu_y = alu_a + alu_b;
      4'd1: alu_y = alu_a - alu_b;
      4'd2: alu_y = alu_a & alu_b;
      4'd3: alu_y = alu_a | alu_b;
      4'd4: alu_y = ~(alu_a | alu_b);
      4'd5: alu_y = alu_a ^ alu_b;
      4'd6: alu_y = alu_b << alu_a[4:0];
      4'd7: alu_y = alu_b >> alu_a[4:0];
      4'd8: alu_y = $signed(alu_b) >>> alu_a[4:0];
      default: alu_y = 32'hDEAD_BEEF;
    endcase
  end
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, y;
    logic [3:0]  f;
    logic        e;
  } vec_t;
  vec_t vt[14];
  logic [31:0] got[8];
  int n;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1;
    in_op = op;
    in_a = a;
    in_b = b;
  endtask
  initial begin
    vt[0]  = '{4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1001, 1'b0};
    vt[1]  = '{4'd1, 32'h5, 32'h5, 32'h0, 4'b0110, 1'b0};
    vt[2]  = '{4'd8, 32'h4, 32'h80000000, 32'hF8000000, 4'b1000, 1'b0};
    vt[3]  = '{4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1'b0};
    vt[4]  = '{4'd3, 32'h0, 32'h0, 32'h0, 4'b0100, 1'b0};
    vt[5]  = '{4'd4, 32'h0, 32'h0, 32'hFFFFFFFF, 4'b1000, 1'b0};
    vt[6]  = '{4'd5, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0, 4'b0100, 1'b0};
    vt[7]  = '{4'd6, 32'h4, 32'h1, 32'h10, 4'b0000, 1'b0};
    vt[8]  = '{4'd7, 32'h1F, 32'h80000000, 32'h1, 4'b0000, 1'b0};
    vt[9]  = '{4'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0110, 1'b0};
    vt[10] = '{4'd1, 32'h0, 32'h1, 32'hFFFFFFFF, 4'b1000, 1'b0};
    vt[11] = '{4'd1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0011, 1'b0};
    vt[12] = '{4'd12, 32'h3, 32'h4, 32'h0, 4'b0100, 1'b1};
    vt[13] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'b0100, 1'b1};
    tick();
    tick();
    reset = 0;
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_op_count", {16'd0, op_count}, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_flags", {28'd0, out_flags}, 0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 0);
    chk("rst_alu_a", alu_a, 0);
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].op, vt[i].a, vt[i].b);
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 1);
      tick();
      in_valid = 0;
      chk($sformatf("v%0d_ctrl", i), {28'd0, alu_ctrl}, vt[i].op > 4'd8 ? 0 : {28'd0, vt[i].op});
      chk($sformatf("v%0d_lat1", i), {31'd0, out_valid}, 0);
      tick();
      chk($sformatf("v%0d_lat2", i), {31'd0, out_valid}, 1);
      chk($sformatf("v%0d_y", i), out_y, vt[i].y);
      chk($sformatf("v%0d_flags", i), {28'd0, out_flags}, {28'd0, vt[i].f});
      chk($sformatf("v%0d_err", i), {31'd0, out_err}, {31'd0, vt[i].e});
      tick();
      chk($sformatf("v%0d_count", i), {16'd0, op_count}, i + 1);
    end
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(4'd0, k, 100);
      else in_valid = 0;
      if (k < 4) chk($sformatf("stream_ready%0d", k), {31'd0, in_ready}, 1);
      if (out_valid && n < 8) begin
        got[n] = out_y;
        n++;
      end
      tick();
    end
    chk("stream_n", n, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("stream_y%0d", k), got[k], 100 + k);
    chk("stream_count", {16'd0, op_count}, 18);
    out_ready = 0;
    drive(4'd0, 1, 2);
    tick();
    drive(4'd0, 3, 4);
    tick();
    drive(4'd0, 10, 20);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_in_ready%0d", k), {31'd0, in_ready}, 0);
      chk($sformatf("bp_valid%0d", k), {31'd0, out_valid}, 1);
      chk($sformatf("bp_y%0d", k), out_y, 3);
      chk($sformatf("bp_alu_a%0d", k), alu_a, 3);
      tick();
    end
    out_ready = 1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid && n < 8) begin
        got[n] = out_y;
        n++;
      end
      tick();
      if (k == 0) in_valid = 0;
    end
    chk("bp_n", n, 3);
    chk("bp_y0", got[0], 3);
    chk("bp_y1", got[1], 7);
    chk("bp_y2", got[2], 30);
    chk("bp_count", {16'd0, op_count}, 21);
    out_ready = 0;
    drive(4'd1, 9, 2);
    tick();
    drive(4'd1, 8, 2);
    tick();
    in_valid = 0;
    chk("pre_rst_valid", {31'd0, out_valid}, 1);
    chk("pre_rst_ready", {31'd0, in_ready}, 0);
    reset = 1;
    tick();
    reset = 0;
    out_ready = 1;
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_count", {16'd0, op_count}, 0);
    chk("mid_rst_ready", {31'd0, in_ready}, 1);
    chk("mid_rst_y", out_y, 0);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) n++;
      tick();
    end
    chk("mid_rst_discard", n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-006 SHALL have port in_op  input  4  operation code, values 0-8 legal.
REQ-007 SHALL have port in_a  input  N  operand A; the low $clog2(N) bits are the shift amount for shifts.
REQ-008 SHALL have port in_b  input  N  operand B; this is the shifted value for shifts.
REQ-009 SHALL have port alu_a  output  N  operand A driven to the external combinational ALU.
REQ-010 SHALL have port alu_b  output  N  operand B driven to the external ALU.
REQ-011 SHALL have port alu_ctrl  output  4  control code driven to the external ALU.
REQ-012 SHALL have port alu_y  input  N  combinational ALU result.
REQ-013 SHALL have port out_valid  output  1  result present.
REQ-014 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-015 SHALL have port out_y  output  N  registered result.
REQ-016 SHALL have port out_flags  output  4  {Negative, Zero, Carry, Overflow}.
REQ-017 SHALL have port out_err  output  1  illegal opcode marker.
REQ-018 SHALL have port op_count  output  16  number of results consumed, wrapping.

Function
REQ-019 SHALL use opcode encoding 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 LSL, 7 LSR, 8 ASR, passed unchanged on alu_ctrl.
REQ-020 SHALL implement a two-stage pipeline: S1 issue register drives alu_a/alu_b/alu_ctrl; S2 result register captures alu_y, flags, and err.
REQ-021 SHALL have latency of exactly 2 cycles from an accepted request to out_valid when out_ready is held high.
REQ-022 SHALL sustain 1 request per cycle when out_ready is held high.
REQ-023 SHALL advance S2 when !s2_valid || out_ready.
REQ-024 SHALL advance S1 when !s1_valid || S2 advances.
REQ-025 SHALL drive in_ready = S1 advance condition, combinationally, without depending on in_valid.
REQ-026 SHALL hold out_y, out_flags, and out_err stable while out_valid && !out_ready.
REQ-027 SHALL hold alu_a, alu_b, and alu_ctrl stable while S1 is stalled.
REQ-028 SHALL compute Z = (out_y == 0) and N = out_y[N-1].
REQ-029 SHALL compute C and V only for ADD/SUB, using an internal N+1-bit sum a + (SUB ? ~b : b) + SUB; C is bit N of that sum.
REQ-030 SHALL compute V = (a[N-1] ^ sum[N-1]) & ~(a[N-1] ^ b[N-1] ^ SUB).
REQ-031 SHALL force C = V = 0 for all opcodes other than ADD/SUB.
REQ-032 SHALL, for opcode 9-15: drive alu_ctrl 0, set out_y 0, set out_flags 4'b0100, set out_err 1; such requests still occupy a slot and are still counted.
REQ-033 SHALL increment op_count on each out handshake, wrapping from 0xFFFF to 0.
REQ-034 SHALL perform S1 capture and S2 drain in the same cycle with no loss or duplication.

Reset
REQ-035 SHALL, while reset is high at a clock edge, clear s1_valid, s2_valid, and op_count.
REQ-036 SHALL, on reset, clear alu_a, alu_b, alu_ctrl, out_y, out_flags, and out_err to 0.
REQ-037 SHALL drive in_ready 1 in the cycle after reset deasserts.
REQ-038 SHALL, on reset mid-operation, discard all in-flight requests without emitting them.

Structure
REQ-039 SHALL place the opcode enum, OP_LAST = 8, and flag bit indices (N=3, Z=2, C=1, V=0) in shared package alu_pkg.
REQ-040 SHALL implement flag generation as one sub-module, alu_flags, that is combinational and parameterised by N.

Verification
REQ-041 SHALL cover: ADD a=0x7FFFFFFF b=1 -> out_y 0x80000000, flags 4'b1001, out_valid 2 cycles after accept.
REQ-042 SHALL cover: SUB a=5 b=5 -> out_y 0, flags 4'b0110 (Z, and C meaning no borrow).
REQ-043 SHALL cover: ASR b=0x80000000 a=4 -> out_y 0xF8000000, flags 4'b1000.
REQ-044 SHALL cover: three back-to-back requests with out_ready low for 3 cycles -> in_ready low after two accepts, outputs held stable, all three results delivered in order once out_ready rises.
REQ-045 SHALL cover: opcode 12 -> out_err 1, out_y 0, flags 4'b0100, op_count incremented.
REQ-046 SHALL cover: reset asserted with both stages valid -> next cycle out_valid 0, op_count 0, in_ready 1.
